aes_pio_handshake: RTL
======================

// Module: aes_pio_handshake
// PURPOSE
//   Hardware end of the NIOS PIO link (to_hw_port/to_hw_sig, to_sw_port/to_sw_sig).
//   Receives 8 x 32-bit words from software over a four-phase handshake:
//   4 key words, then 4 message words. It then starts the crypto core, waits for
//   the 128-bit result, and returns it to software as 4 x 32-bit words.
//   Sits in the top level between nios_system exports and the AES core.
// PARAMETERS
//   WORD_W     32  PIO data width
//   IN_WORDS    8  words received per job (first half key, second half message)
//   OUT_WORDS   4  words returned per job
// PORTS
//   clk_clk        in   1    system clock; same domain as the PIOs, no synchronisers
//   reset_reset_n  in   1    synchronous, active-low reset
//   hw_sig_i       in   2    from to_hw_sig_export: 00 IDLE, 01 WR, 10 RD_ACK, 11 ABORT
//   hw_data_i      in   32   from to_hw_port_export
//   sw_sig_o       out  2    to to_sw_sig_export: 00 READY, 01 WR_ACK, 10 DVALID, 11 BUSY
//   sw_data_o      out  32   to to_sw_port_export
//   key_o          out  128  assembled key; stable from core_start_o until the next job
//   msg_o          out  128  assembled message; same stability as key_o
//   core_start_o   out  1    one-cycle start pulse to the core
//   core_done_i    in   1    core result valid (level or pulse; sampled in WAIT_CORE only)
//   core_result_i  in   128  core result, captured on the cycle core_done_i is seen
// BEHAVIOUR
//   Reset (reset_reset_n=0 at a clk edge):
//     state=RX_WAIT; sw_sig_o=00; sw_data_o=0; key_o=0; msg_o=0; core_start_o=0;
//     word index=0. All outputs are registered.
//   States: RX_WAIT, RX_ACK, START, WAIT_CORE, TX_PRESENT, TX_DROP.
//   RX_WAIT (sw_sig 00): on hw_sig_i==01, write hw_data_i into word[idx] -> RX_ACK.
//     Word 0 -> key[127:96] ... word 3 -> key[31:0]; word 4 -> msg[127:96] ... word 7 -> msg[31:0].
//   RX_ACK (sw_sig 01): hold until hw_sig_i==00.
//     Then, if idx==IN_WORDS-1: idx=0 -> START; otherwise idx++ -> RX_WAIT.
//     A held 01 never latches twice; 10 is ignored here.
//   START: core_start_o=1 for exactly this cycle; sw_sig 11 -> WAIT_CORE.
//   WAIT_CORE (sw_sig 11): on core_done_i, capture core_result_i, idx=0 -> TX_PRESENT.
//     core_done_i seen in any other state is ignored.
//   TX_PRESENT: sw_data_o=result word[idx] (word 0 = result[127:96]), sw_sig 10.
//     sw_data_o is valid no later than the cycle sw_sig_o becomes 10.
//     On hw_sig_i==10 -> TX_DROP.
//   TX_DROP (sw_sig 00, sw_data_o held): wait for hw_sig_i==00.
//     Then, if idx==OUT_WORDS-1: idx=0, sw_data_o=0 -> RX_WAIT; otherwise idx++ -> TX_PRESENT.
//   Latency: handshake edge to sw_sig response is 1 clk. Core start is 1 clk after the
//     last RX_ACK drop. TX_PRESENT is 1 clk after core_done_i.
//   ABORT: hw_sig_i==11 in any state -> next cycle RX_WAIT, idx=0, sw_sig 00, sw_data_o=0.
//     key_o/msg_o keep their partial contents. A pending core result is discarded.
//     Abort overrides every other transition in the same cycle.
//   Unexpected codes (e.g. 10 in RX_WAIT, 01 in TX_PRESENT) are ignored; state holds.
//   Reset mid-job has the same effect as ABORT and also clears key_o/msg_o.
// STRUCTURE
//   Shared package aes_io_pkg: state enum, HW_SIG_* and SW_SIG_* 2-bit codes, WORD_W.
//   Sub-module pio_word_mux: selects the 32-bit slice of a 128-bit vector by a 2-bit index
//     (combinational); its output is registered into sw_data_o by this block.
//   FSM, index counter and key/msg/result registers stay in this module.
// TESTING
//   1. Reset held 3 clk -> sw_sig_o=00, core_start_o=0, key_o=msg_o=0.
//   2. Send 8 words 0x00010203..0x1C1D1E1F with full 4-phase handshake:
//      -> key_o=0x000102030405060708090A0B0C0D0E0F, msg_o=0x101112...1F.
//      -> One core_start_o pulse; sw_sig_o=11.
//   3. core_done_i with result 0xDEADBEEF_CAFEF00D_01234567_89ABCDEF:
//      -> sw_data_o=0xDEADBEEF with sw_sig 10; after RD_ACK and drop, 0xCAFEF00D; ... ; then RX_WAIT.
//   4. Hold hw_sig_i=01 for 20 clk on word 0 -> exactly one latch; idx advances only after 00.
//   5. ABORT after 5 words -> next clk sw_sig 00. A new 8-word job then produces correct
//      key_o/msg_o with no stale words.
//   6. core_done_i asserted during RX -> ignored. Abort in WAIT_CORE -> no TX words emitted.

Source files
------------

// File: rtl/aes_io_pkg.sv
// Shared definitions for the NIOS PIO <-> crypto core handshake.
//   - state_t       : handshake FSM states
//   - HW_SIG_*      : codes software drives on to_hw_sig
//   - SW_SIG_*      : codes hardware drives on to_sw_sig
//   - WORD_W, IN_WORDS, OUT_WORDS and derived index limits
package aes_io_pkg;

   localparam int WORD_W    = 32;
   localparam int IN_WORDS  = 8;
   localparam int OUT_WORDS = 4;
   localparam int BLOCK_W   = 128;

   localparam logic [2:0] RX_LAST_IDX = 3'(IN_WORDS - 1);
   localparam logic [2:0] TX_LAST_IDX = 3'(OUT_WORDS - 1);

   localparam logic [1:0] HW_SIG_IDLE   = 2'b00;
   localparam logic [1:0] HW_SIG_WR     = 2'b01;
   localparam logic [1:0] HW_SIG_RD_ACK = 2'b10;
   localparam logic [1:0] HW_SIG_ABORT  = 2'b11;

   localparam logic [1:0] SW_SIG_READY  = 2'b00;
   localparam logic [1:0] SW_SIG_WR_ACK = 2'b01;
   localparam logic [1:0] SW_SIG_DVALID = 2'b10;
   localparam logic [1:0] SW_SIG_BUSY   = 2'b11;

   typedef enum logic [2:0] {
      ST_RX_WAIT    = 3'd0,
      ST_RX_ACK     = 3'd1,
      ST_START      = 3'd2,
      ST_WAIT_CORE  = 3'd3,
      ST_TX_PRESENT = 3'd4,
      ST_TX_DROP    = 3'd5
   } state_t;

endpackage

// File: rtl/pio_word_mux.sv
// Picks one 32-bit word out of a 128-bit block; word 0 is the most
// significant slice, matching the order software sends/receives words.
//   vec  : 128-bit source block
//   sel  : word index 0..3
//   word : selected 32-bit slice (combinational)
module pio_word_mux
   import aes_io_pkg::*;
(
   input  logic [BLOCK_W-1:0] vec,
   input  logic [1:0]         sel,
   output logic [WORD_W-1:0]  word
);

   // Word select, MSW first.
   always_comb begin
      word = vec[127:96];
      case (sel)
         2'd0:    word = vec[127:96];
         2'd1:    word = vec[95:64];
         2'd2:    word = vec[63:32];
         2'd3:    word = vec[31:0];
         default: word = vec[127:96];
      endcase
   end

endmodule

// File: rtl/aes_pio_handshake.sv
// Hardware end of the NIOS PIO link. Collects 4 key words and 4 message
// words over a four-phase handshake, pulses the crypto core, waits for its
// 128-bit result and hands it back to software as 4 words.
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   hw_sig_i, hw_data_i    : software -> hardware handshake code and data
//   sw_sig_o, sw_data_o    : hardware -> software handshake code and data
//   key_o, msg_o           : assembled key/message presented to the core
//   core_start_o           : one-cycle start pulse
//   core_done_i            : result valid, honoured only while waiting for it
//   core_result_i          : 128-bit core result
module aes_pio_handshake
   import aes_io_pkg::*;
(
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic [1:0]         hw_sig_i,
   input  logic [WORD_W-1:0]  hw_data_i,
   output logic [1:0]         sw_sig_o,
   output logic [WORD_W-1:0]  sw_data_o,
   output logic [BLOCK_W-1:0] key_o,
   output logic [BLOCK_W-1:0] msg_o,
   output logic               core_start_o,
   input  logic               core_done_i,
   input  logic [BLOCK_W-1:0] core_result_i
);

   state_t             state_r;
   logic [2:0]         idx_r;
   logic [BLOCK_W-1:0] key_r;
   logic [BLOCK_W-1:0] msg_r;
   logic [BLOCK_W-1:0] result_r;
   logic [1:0]         sw_sig_r;
   logic [WORD_W-1:0]  sw_data_r;
   logic               core_start_r;

   logic [1:0]         slot_s;
   logic [BLOCK_W-1:0] mux_vec_s;
   logic [1:0]         mux_sel_s;
   logic [WORD_W-1:0]  mux_word_s;

   // Word 0 lands in the top slice, so the bit slot is the inverted index.
   assign slot_s = ~idx_r[1:0];

   // sw_data_o must be valid on the same cycle DVALID appears, so the mux
   // looks one word ahead: the live core result while waiting for it, the
   // next stored word while the current one is being dropped.
   always_comb begin
      mux_vec_s = result_r;
      mux_sel_s = idx_r[1:0] + 2'd1;
      if (state_r == ST_WAIT_CORE) begin
         mux_vec_s = core_result_i;
         mux_sel_s = 2'd0;
      end else begin
         mux_vec_s = result_r;
         mux_sel_s = idx_r[1:0] + 2'd1;
      end
   end

   pio_word_mux u_word_mux (
      .vec  (mux_vec_s),
      .sel  (mux_sel_s),
      .word (mux_word_s)
   );

   // Handshake FSM with index counter, data registers and registered outputs.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_r      <= ST_RX_WAIT;
         idx_r        <= 3'd0;
         key_r        <= {BLOCK_W{1'b0}};
         msg_r        <= {BLOCK_W{1'b0}};
         result_r     <= {BLOCK_W{1'b0}};
         sw_sig_r     <= SW_SIG_READY;
         sw_data_r    <= {WORD_W{1'b0}};
         core_start_r <= 1'b0;
      end else begin
         core_start_r <= 1'b0;
         if (hw_sig_i == HW_SIG_ABORT) begin
            // Abort wins over everything; partial key/msg are left as-is.
            state_r   <= ST_RX_WAIT;
            idx_r     <= 3'd0;
            sw_sig_r  <= SW_SIG_READY;
            sw_data_r <= {WORD_W{1'b0}};
         end else begin
            case (state_r)
               ST_RX_WAIT: begin
                  if (hw_sig_i == HW_SIG_WR) begin
                     if (idx_r[2] == 1'b0) begin
                        key_r[{slot_s, 5'd0} +: WORD_W] <= hw_data_i;
                     end else begin
                        msg_r[{slot_s, 5'd0} +: WORD_W] <= hw_data_i;
                     end
                     state_r  <= ST_RX_ACK;
                     sw_sig_r <= SW_SIG_WR_ACK;
                  end
               end
               ST_RX_ACK: begin
                  if (hw_sig_i == HW_SIG_IDLE) begin
                     if (idx_r == RX_LAST_IDX) begin
                        idx_r        <= 3'd0;
                        state_r      <= ST_START;
                        sw_sig_r     <= SW_SIG_BUSY;
                        core_start_r <= 1'b1;
                     end else begin
                        idx_r    <= idx_r + 3'd1;
                        state_r  <= ST_RX_WAIT;
                        sw_sig_r <= SW_SIG_READY;
                     end
                  end
               end
               ST_START: begin
                  state_r <= ST_WAIT_CORE;
               end
               ST_WAIT_CORE: begin
                  if (core_done_i) begin
                     result_r  <= core_result_i;
                     idx_r     <= 3'd0;
                     sw_data_r <= mux_word_s;
                     sw_sig_r  <= SW_SIG_DVALID;
                     state_r   <= ST_TX_PRESENT;
                  end
               end
               ST_TX_PRESENT: begin
                  if (hw_sig_i == HW_SIG_RD_ACK) begin
                     sw_sig_r <= SW_SIG_READY;
                     state_r  <= ST_TX_DROP;
                  end
               end
               ST_TX_DROP: begin
                  if (hw_sig_i == HW_SIG_IDLE) begin
                     if (idx_r == TX_LAST_IDX) begin
                        idx_r     <= 3'd0;
                        sw_data_r <= {WORD_W{1'b0}};
                        state_r   <= ST_RX_WAIT;
                     end else begin
                        idx_r     <= idx_r + 3'd1;
                        sw_data_r <= mux_word_s;
                        sw_sig_r  <= SW_SIG_DVALID;
                        state_r   <= ST_TX_PRESENT;
                     end
                  end
               end
               default: begin
                  state_r   <= ST_RX_WAIT;
                  idx_r     <= 3'd0;
                  sw_sig_r  <= SW_SIG_READY;
                  sw_data_r <= {WORD_W{1'b0}};
               end
            endcase
         end
      end
   end

   assign sw_sig_o     = sw_sig_r;
   assign sw_data_o    = sw_data_r;
   assign key_o        = key_r;
   assign msg_o        = msg_r;
   assign core_start_o = core_start_r;

endmodule
